// File: rtl/bf16_accum_seq.sv
// bf16_accum_seq: streaming bf16 accumulator; each registered beat is folded into acc_q via Add_Sub.
// Optional BF16_ACC_FTZ_EN: flush subnormal values written to acc_q to signed zero.
module Add_Sub (
  input  logic [15:0] A,
  input  logic [15:0] B,
  input  logic        inst,
  output logic [15:0] C
);
  logic        sb, a_ge, eff_sub, sx, sticky, up;
  logic        a_nan, b_nan, a_inf, b_inf;
  logic [7:0]  ex, ey, exe, eye, d, dc, sh, e_f, mx, my;
  logic [4:0]  lz;
  logic [35:0] t;
  logic [17:0] y18;
  logic [18:0] r, n;
  logic [14:0] rnd;
  always_comb begin
    sb      = B[15] ^ ~inst;
    a_nan   = &A[14:7] & |A[6:0];
    b_nan   = &B[14:7] & |B[6:0];
    a_inf   = &A[14:7] & ~|A[6:0];
    b_inf   = &B[14:7] & ~|B[6:0];
    a_ge    = A[14:0] >= B[14:0];
    eff_sub = A[15] ^ sb;
    sx      = a_ge ? A[15] : sb;
    ex      = a_ge ? A[14:7] : B[14:7];
    ey      = a_ge ? B[14:7] : A[14:7];
    mx      = {|ex, a_ge ? A[6:0] : B[6:0]};
    my      = {|ey, a_ge ? B[6:0] : A[6:0]};
    exe     = ex | {7'b0, ~|ex};
    eye     = ey | {7'b0, ~|ey};
    d       = exe - eye;
    dc      = (d > 8'd28) ? 8'd28 : d;
    t       = {my, 28'b0} >> dc;
    sticky  = |t[17:0];
    y18     = {t[35:19], t[18] | sticky};
    r       = eff_sub ? {1'b0, mx, 10'b0} - {1'b0, y18} : {1'b0, mx, 10'b0} + {1'b0, y18};
    lz      = 5'd19;
    for (int i = 0; i < 19; i++) if (r[i]) lz = 5'(18 - i);
    // Subnormal results stop normalising once the exponent field reaches zero.
    sh      = ({3'b0, lz} > exe) ? exe : {3'b0, lz};
    n       = r << sh;
    e_f     = n[18] ? exe + 8'd1 - sh : 8'd0;
    up      = n[10] & (|n[9:0] | n[11]);
    rnd     = {e_f, n[17:11]} + {14'b0, up};
    if (a_nan | b_nan | (a_inf & b_inf & eff_sub)) C = 16'h7FC0;
    else if (a_inf) C = A;
    else if (b_inf) C = {sb, 15'h7F80};
    else if (r == 19'd0) C = {A[15] & sb, 15'h0};
    else if (e_f == 8'hFF) C = {sx, 15'h7F80};
    else C = {sx, rnd};
  end
endmodule

module bf16_accum_seq #(
  parameter int CNT_W = 8
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             start_i,
  input  logic             flush_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [15:0]      in_data_i,
  input  logic             in_sub_i,
  input  logic             in_last_i,
  output logic             res_valid_o,
  input  logic             res_ready_i,
  output logic [15:0]      res_data_o,
  output logic [CNT_W-1:0] cnt_o,
  output logic             nan_o
);
  typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_e;
  state_e             state_q, state_d;
  logic [15:0]        acc_q, acc_d, op_q, op_d, add_c, wr;
  logic               op_sub_q, op_sub_d, op_last_q, op_last_d, op_vld_q, op_vld_d;
  logic               first_q, first_d, nan_q, nan_d, wr_nan;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  function automatic logic [15:0] ftz(input logic [15:0] v);
`ifdef BF16_ACC_FTZ_EN
    return (~|v[14:7] & |v[6:0]) ? {v[15], 15'h0} : v;
`else
    return v;
`endif
  endfunction
  Add_Sub u_add (.A(acc_q), .B(op_q), .inst(~op_sub_q), .C(add_c));
  assign res_data_o = acc_q;
  assign cnt_o      = cnt_q;
  assign nan_o      = nan_q;
  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    op_d        = op_q;
    op_sub_d    = op_sub_q;
    op_last_d   = op_last_q;
    op_vld_d    = op_vld_q;
    first_d     = first_q;
    nan_d       = nan_q;
    cnt_d       = cnt_q;
    in_ready_o  = (state_q == ACCUM) & ~op_vld_q;
    res_valid_o = state_q == DONE;
    // The first beat is copied (sign-flipped for sub) so 0 - x is exactly -x.
    wr          = first_q ? (op_sub_q ? {~op_q[15], op_q[14:0]} : op_q) : add_c;
    wr_nan      = first_q ? (&op_q[14:7] & |op_q[6:0]) : add_c == 16'h7FC0;
    if (flush_i) begin
      state_d  = IDLE;
      op_vld_d = 1'b0;
      nan_d    = 1'b0;
    end else if (state_q == IDLE) begin
      if (start_i) begin
        state_d  = ACCUM;
        acc_d    = 16'h0000;
        cnt_d    = '0;
        nan_d    = 1'b0;
        first_d  = 1'b1;
        op_vld_d = 1'b0;
      end
    end else if (state_q == ACCUM) begin
      if (in_valid_i & in_ready_o) begin
        op_d      = in_data_i;
        op_sub_d  = in_sub_i;
        op_last_d = in_last_i;
        op_vld_d  = 1'b1;
        cnt_d     = (cnt_q == {CNT_W{1'b1}}) ? cnt_q : cnt_q + CNT_W'(1);
      end
      if (op_vld_q) begin
        acc_d    = ftz(wr);
        op_vld_d = 1'b0;
        first_d  = 1'b0;
        nan_d    = nan_q | wr_nan;
        state_d  = op_last_q ? DONE : ACCUM;
      end
    end else if (res_ready_i) begin
      state_d = IDLE;
    end
  end
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q   <= IDLE;
      acc_q     <= 16'h0000;
      op_q      <= 16'h0000;
      op_sub_q  <= 1'b0;
      op_last_q <= 1'b0;
      op_vld_q  <= 1'b0;
      first_q   <= 1'b0;
      nan_q     <= 1'b0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      acc_q     <= acc_d;
      op_q      <= op_d;
      op_sub_q  <= op_sub_d;
      op_last_q <= op_last_d;
      op_vld_q  <= op_vld_d;
      first_q   <= first_d;
      nan_q     <= nan_d;
      cnt_q     <= cnt_d;
    end
  end
endmodule

// File: tb/tb_bf16_accum_seq.sv
// tb_bf16_accum_seq: vector table, corner sequences and random runs against a real-arithmetic bf16 model.
module tb_bf16_accum_seq;
  logic        clk_i = 1'b0;
  logic        rst_ni, start_i, flush_i, in_valid_i, in_ready_o, in_sub_i, in_last_i;
  logic        res_valid_o, res_ready_i, nan_o;
  logic [15:0] in_data_i, res_data_o;
  logic [7:0]  cnt_o;
  int          n_chk = 0;
  int          n_fail = 0;

  always #5 clk_i = ~clk_i;

  bf16_accum_seq #(.CNT_W(8)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .start_i(start_i), .flush_i(flush_i),
    .in_valid_i(in_valid_i), .in_ready_o(in_ready_o), .in_data_i(in_data_i),
    .in_sub_i(in_sub_i), .in_last_i(in_last_i), .res_valid_o(res_valid_o),
    .res_ready_i(res_ready_i), .res_data_o(res_data_o), .cnt_o(cnt_o), .nan_o(nan_o)
  );

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic        sub;
    logic [15:0] res;
    logic        nan;
  } vec_t;
  vec_t vecs [14];

  function automatic real bf2r(input logic [15:0] b);
    real v;
    if (b[14:0] == 15'h0) return 0.0;
    v = (1.0 + real'(b[6:0]) / 128.0) * (2.0 ** real'(int'(b[14:7]) - 127));
    return b[15] ? -v : v;
  endfunction

  // Round a real (normal bf16 range) to bf16, nearest-even.
  function automatic logic [15:0] r2bf(input real x);
    logic [63:0] d;
    logic [15:0] e;
    logic        up;
    d = $realtobits(x);
    if (d[62:0] == 63'd0) return {d[63], 15'h0};
    e  = 16'(d[62:52]) - 16'd896;
    up = d[44] & (|d[43:0] | d[45]);
    return {d[63], 15'({e[7:0], d[51:45]} + 15'(up))};
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) @(negedge clk_i);
  endtask

  task automatic start_run();
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
  endtask

  task automatic send(input logic [15:0] d, input logic s, input logic l);
    int w;
    w = 0;
    in_valid_i = 1'b1;
    in_data_i  = d;
    in_sub_i   = s;
    in_last_i  = l;
    while (!in_ready_o && w < 20) begin
      tick();
      w++;
    end
    chk("send_ready", 32'(in_ready_o), 32'd1);
    tick();
    in_valid_i = 1'b0;
    in_last_i  = 1'b0;
  endtask

  task automatic get_result(input string nm, input logic [15:0] d, input logic [7:0] c, input logic nn);
    int w;
    w = 0;
    while (!res_valid_o && w < 20) begin
      tick();
      w++;
    end
    chk({nm, "_valid"}, 32'(res_valid_o), 32'd1);
    chk({nm, "_data"}, 32'(res_data_o), 32'(d));
    chk({nm, "_cnt"}, 32'(cnt_o), 32'(c));
    chk({nm, "_nan"}, 32'(nan_o), 32'(nn));
    res_ready_i = 1'b1;
    tick();
    res_ready_i = 1'b0;
    chk({nm, "_released"}, 32'(res_valid_o), 32'd0);
  endtask

  initial begin
    int          nb, bcnt;
    logic [15:0] op, exp_acc;
    logic        s;
    real         v;
    vecs[0]  = '{16'h3F80, 16'h4000, 1'b0, 16'h4040, 1'b0};
    vecs[1]  = '{16'h4040, 16'h3F80, 1'b1, 16'h4000, 1'b0};
    vecs[2]  = '{16'h3F80, 16'h3F80, 1'b1, 16'h0000, 1'b0};
    vecs[3]  = '{16'h4000, 16'hC000, 1'b0, 16'h0000, 1'b0};
    vecs[4]  = '{16'h3F80, 16'h3B80, 1'b0, 16'h3F80, 1'b0};
    vecs[5]  = '{16'h3F81, 16'h3B80, 1'b0, 16'h3F82, 1'b0};
    vecs[6]  = '{16'h7F7F, 16'h7F7F, 1'b0, 16'h7F80, 1'b0};
    vecs[7]  = '{16'h7F80, 16'hFF80, 1'b0, 16'h7FC0, 1'b1};
    vecs[8]  = '{16'h3F80, 16'h7F80, 1'b0, 16'h7F80, 1'b0};
`ifdef BF16_ACC_FTZ_EN
    vecs[9]  = '{16'h0080, 16'h0001, 1'b1, 16'h0000, 1'b0};
`else
    vecs[9]  = '{16'h0080, 16'h0001, 1'b1, 16'h007F, 1'b0};
`endif
    vecs[10] = '{16'hC040, 16'h4040, 1'b0, 16'h0000, 1'b0};
    vecs[11] = '{16'h4300, 16'h3F80, 1'b0, 16'h4301, 1'b0};
    vecs[12] = '{16'h4380, 16'h3F80, 1'b0, 16'h4380, 1'b0};
    vecs[13] = '{16'h3F80, 16'h7FC1, 1'b0, 16'h7FC0, 1'b1};
    rst_ni = 1'b0; start_i = 1'b0; flush_i = 1'b0; in_valid_i = 1'b0;
    in_data_i = 16'h0; in_sub_i = 1'b0; in_last_i = 1'b0; res_ready_i = 1'b0;
    tick(3);
    chk("rst_in_ready", 32'(in_ready_o), 32'd0);
    chk("rst_res_valid", 32'(res_valid_o), 32'd0);
    chk("rst_res_data", 32'(res_data_o), 32'h0);
    chk("rst_cnt", 32'(cnt_o), 32'd0);
    chk("rst_nan", 32'(nan_o), 32'd0);
    rst_ni = 1'b1;
    tick();
    // In IDLE a valid beat must not be taken.
    in_valid_i = 1'b1;
    tick(2);
    chk("idle_in_ready", 32'(in_ready_o), 32'd0);
    chk("idle_cnt", 32'(cnt_o), 32'd0);
    in_valid_i = 1'b0;

    for (int i = 0; i < 14; i++) begin
      start_run();
      send(vecs[i].a, 1'b0, 1'b0);
      send(vecs[i].b, vecs[i].sub, 1'b1);
      get_result($sformatf("vec%0d", i), vecs[i].res, 8'd2, vecs[i].nan);
    end
    chk("nan_sticky_idle", 32'(nan_o), 32'd1);
    start_run();
    chk("nan_cleared_by_start", 32'(nan_o), 32'd0);
    chk("cnt_cleared_by_start", 32'(cnt_o), 32'd0);
    send(16'h3F80, 1'b1, 1'b1);
    get_result("single_sub", 16'hBF80, 8'd1, 1'b0);

    // Latency n+2, then hold in DONE with start_i and in_valid_i asserted.
    start_run();
    send(16'h3F80, 1'b0, 1'b0);
    send(16'h4000, 1'b0, 1'b1);
    chk("lat_n1_valid", 32'(res_valid_o), 32'd0);
    tick();
    chk("lat_n2_valid", 32'(res_valid_o), 32'd1);
    for (int k = 0; k < 5; k++) begin
      chk("hold_valid", 32'(res_valid_o), 32'd1);
      chk("hold_data", 32'(res_data_o), 32'h4040);
      chk("hold_in_ready", 32'(in_ready_o), 32'd0);
      start_i = 1'b1;
      in_valid_i = 1'b1;
      tick();
    end
    chk("hold_cnt", 32'(cnt_o), 32'd2);
    res_ready_i = 1'b1;
    tick();
    res_ready_i = 1'b0; start_i = 1'b0; in_valid_i = 1'b0;
    chk("hs_res_valid", 32'(res_valid_o), 32'd0);
    chk("hs_start_ignored", 32'(in_ready_o), 32'd0);
    tick();
    chk("hs_still_idle", 32'(in_ready_o), 32'd0);
    chk("hs_cnt_kept", 32'(cnt_o), 32'd2);

    // Flush while a beat is in flight.
    start_run();
    send(16'h3F80, 1'b0, 1'b1);
    flush_i = 1'b1;
    tick();
    flush_i = 1'b0;
    chk("flush_in_ready", 32'(in_ready_o), 32'd0);
    chk("flush_acc", 32'(res_data_o), 32'h0000);
    tick(3);
    chk("flush_no_result", 32'(res_valid_o), 32'd0);

    // Back-to-back beats: ready alternates.
    start_run();
    bcnt = 0;
    in_valid_i = 1'b1;
    in_data_i = 16'h3F80;
    in_sub_i = 1'b0;
    for (int k = 0; k < 8; k++) begin
      chk($sformatf("b2b_ready%0d", k), 32'(in_ready_o), 32'(k % 2 == 0));
      if (in_ready_o) begin
        in_last_i = (bcnt == 3);
        bcnt++;
      end
      tick();
    end
    in_valid_i = 1'b0;
    in_last_i = 1'b0;
    get_result("b2b", 16'h4080, 8'd4, 1'b0);

    // Beat counter saturates.
    start_run();
    for (int k = 0; k < 257; k++) send(16'h0000, 1'b0, k == 256);
    get_result("sat", 16'h0000, 8'd255, 1'b0);

    for (int r = 0; r < 40; r++) begin
      nb = $urandom_range(1, 8);
      exp_acc = 16'h0;
      start_run();
      for (int b = 0; b < nb; b++) begin
        op = {1'($urandom), 8'($urandom_range(120, 134)), 7'($urandom)};
        s = 1'($urandom);
        v = s ? -bf2r(op) : bf2r(op);
        exp_acc = (b == 0) ? r2bf(v) : r2bf(bf2r(exp_acc) + v);
        tick($urandom_range(0, 2));
        send(op, s, b == nb - 1);
      end
      tick($urandom_range(0, 3));
      get_result($sformatf("rnd%0d", r), exp_acc, 8'(nb), 1'b0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
